// File: rtl/ula_seq.sv
// ula_seq: single-cycle base ALU plus iterative RV64M multiply/divide behind valid/ready handshakes
module ula_seq #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic [N-1:0] dataA,
  input  logic [N-1:0] dataB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ALUOut,
  output logic         Overflow,
  output logic         Carry,
  output logic         Negative,
  output logic         Zero
);
  localparam int SHIFT_BITS = $clog2(N);
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [2*N-1:0] acc, prod, mstep, dstep;
  logic [N-1:0] x, diff, ma, mb, bb, base_res, m_res, q, r;
  logic [N:0] sum, msum;
  logic [SHIFT_BITS-1:0] cnt, sh;
  logic [2:0] f3;
  logic sa, sb, dz, a_sgn, b_sgn, sub, is_as, b_c, b_ov, dge;
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_nx = state == IDLE ? (in_valid ? (op[4] ? BUSY : DONE) : IDLE)
             : state == BUSY ? (cnt == SHIFT_BITS'(N-1) ? FIX : BUSY)
             : state == FIX  ? DONE
             : (out_ready ? IDLE : DONE);
  end
  always_comb begin
    a_sgn = op[2] ? ~op[0] : op[1] ^ op[0];
    b_sgn = op[2] ? ~op[0] : ~op[1] & op[0];
    ma = (a_sgn & dataA[N-1]) ? -dataA : dataA;
    mb = (b_sgn & dataB[N-1]) ? -dataB : dataB;
    sub = op[3];
    bb = sub ? ~dataB : dataB;
    sum = {1'b0, dataA} + {1'b0, bb} + {{N{1'b0}}, sub};
    sh = dataB[SHIFT_BITS-1:0];
    is_as = op[2:0] == 3'b000;
    b_c = is_as & sum[N];
    b_ov = is_as & (dataA[N-1] == bb[N-1]) & (sum[N-1] != dataA[N-1]);
    base_res = '0;
    case (op[3:0])
      4'b0000, 4'b1000: base_res = sum[N-1:0];
      4'b0111: base_res = dataA & dataB;
      4'b0110: base_res = dataA | dataB;
      4'b0100: base_res = dataA ^ dataB;
      4'b0001: base_res = dataA << sh;
      4'b0101: base_res = dataA >> sh;
      4'b1101: base_res = $signed(dataA) >>> sh;
      4'b0010: base_res = {{(N-1){1'b0}}, $signed(dataA) < $signed(dataB)};
      4'b0011: base_res = {{(N-1){1'b0}}, dataA < dataB};
      default: base_res = '0;
    endcase
  end
  always_comb begin
    msum = {1'b0, acc[2*N-1:N]} + {1'b0, x};
    mstep = acc[0] ? {msum, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};
    dge = acc[2*N-1:N-1] >= {1'b0, x};
    diff = acc[2*N-2:N-1] - x;
    dstep = dge ? {diff, acc[N-2:0], 1'b1} : {acc[2*N-2:0], 1'b0};
    prod = (sa ^ sb) ? -acc : acc;
    q = ((sa ^ sb) & ~dz) ? -acc[N-1:0] : acc[N-1:0];
    r = sa ? -acc[2*N-1:N] : acc[2*N-1:N];
    m_res = f3[2] ? (f3[1] ? r : q) : (f3 == 3'b000 ? prod[N-1:0] : prod[2*N-1:N]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ALUOut <= '0;
      Overflow <= 1'b0;
      Carry <= 1'b0;
      Negative <= 1'b0;
      Zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid && !op[4]) begin
        ALUOut <= base_res;
        Overflow <= b_ov;
        Carry <= b_c;
        Negative <= base_res[N-1];
        Zero <= base_res == '0;
      end
      if (state == IDLE && in_valid && op[4]) begin
        sa <= a_sgn & dataA[N-1];
        sb <= b_sgn & dataB[N-1];
        dz <= dataB == '0;
        f3 <= op[2:0];
        x <= op[2] ? mb : ma;
        acc <= {{N{1'b0}}, op[2] ? ma : mb};
        cnt <= '0;
      end
      if (state == BUSY) begin
        acc <= f3[2] ? dstep : mstep;
        cnt <= cnt + SHIFT_BITS'(1);
      end
      if (state == FIX) begin
        ALUOut <= m_res;
        Overflow <= 1'b0;
        Carry <= 1'b0;
        Negative <= m_res[N-1];
        Zero <= m_res == '0;
      end
    end
  end
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed self-checking bench for ula_seq at N=8
module tb_ula_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [4:0] op = '0;
  logic [7:0] dataA = '0;
  logic [7:0] dataB = '0;
  logic in_ready, out_valid, Overflow, Carry, Negative, Zero;
  logic [7:0] ALUOut;
  int checks = 0;
  int errors = 0;
  int seen;
  always #5 clk = ~clk;
  ula_seq #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dataA(dataA), .dataB(dataB), .out_valid(out_valid), .out_ready(out_ready),
    .ALUOut(ALUOut), .Overflow(Overflow), .Carry(Carry), .Negative(Negative), .Zero(Zero)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic op_chk(input string tag, input logic [4:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input logic [3:0] fl, input int elat);
    int lat;
    int g;
    in_valid = 1'b1;
    op = o;
    dataA = a;
    dataB = b;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = ~o;
    dataA = ~a;
    dataB = ~b;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " result"}, 64'(ALUOut), 64'(exp));
    chk({tag, " flags"}, 64'({Overflow, Carry, Negative, Zero}), 64'(fl));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset ALUOut", 64'(ALUOut), 64'd0);
    chk("reset flags", 64'({Overflow, Carry, Negative, Zero}), 64'd0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    op = 5'b10101;
    dataA = 8'd200;
    dataB = 8'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midbusy reset out_valid", 64'(out_valid), 64'd0);
    chk("midbusy reset in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midbusy no result", 64'(seen), 64'd0);
    op_chk("ADD ovf", 5'b00000, 8'h7F, 8'h01, 8'h80, 4'b1010, 1);
    op_chk("SUB zero", 5'b01000, 8'h05, 8'h05, 8'h00, 4'b0101, 1);
    op_chk("ADD carry", 5'b00000, 8'hFF, 8'h01, 8'h00, 4'b0101, 1);
    op_chk("SUB borrow", 5'b01000, 8'h00, 8'h01, 8'hFF, 4'b0010, 1);
    op_chk("SUB ovf", 5'b01000, 8'h80, 8'h01, 8'h7F, 4'b1100, 1);
    op_chk("AND", 5'b00111, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
    op_chk("OR", 5'b00110, 8'hF0, 8'h0C, 8'hFC, 4'b0010, 1);
    op_chk("XOR", 5'b00100, 8'hF0, 8'h3C, 8'hCC, 4'b0010, 1);
    op_chk("SLL", 5'b00001, 8'h81, 8'h09, 8'h02, 4'b0000, 1);
    op_chk("SRL", 5'b00101, 8'h80, 8'h03, 8'h10, 4'b0000, 1);
    op_chk("SRA", 5'b01101, 8'h80, 8'h03, 8'hF0, 4'b0010, 1);
    op_chk("SLTU", 5'b00011, 8'hFF, 8'h01, 8'h00, 4'b0001, 1);
    op_chk("illegal", 5'b01111, 8'h12, 8'h34, 8'h00, 4'b0001, 1);
    op_chk("MULH", 5'b10001, 8'h80, 8'h80, 8'h40, 4'b0000, 10);
    op_chk("MULHU", 5'b11011, 8'hFF, 8'hFF, 8'hFE, 4'b0010, 10);
    op_chk("MUL", 5'b10000, 8'hFF, 8'hFF, 8'h01, 4'b0000, 10);
    op_chk("MULHSU", 5'b10010, 8'hFF, 8'h02, 8'hFF, 4'b0010, 10);
    op_chk("DIV ovf", 5'b10100, 8'h80, 8'hFF, 8'h80, 4'b0010, 10);
    op_chk("REM ovf", 5'b10110, 8'h80, 8'hFF, 8'h00, 4'b0001, 10);
    op_chk("DIVU by0", 5'b10101, 8'h2A, 8'h00, 8'hFF, 4'b0010, 10);
    op_chk("REMU by0", 5'b10111, 8'h2A, 8'h00, 8'h2A, 4'b0000, 10);
    op_chk("DIV neg", 5'b10100, 8'hF9, 8'h02, 8'hFD, 4'b0010, 10);
    op_chk("REM neg", 5'b10110, 8'hF9, 8'h02, 8'hFF, 4'b0010, 10);
    op_chk("DIVU", 5'b10101, 8'd200, 8'd7, 8'd28, 4'b0000, 10);
    in_valid = 1'b1;
    op = 5'b00010;
    dataA = 8'h80;
    dataB = 8'h01;
    @(posedge clk);
    #1;
    chk("SLT valid", 64'(out_valid), 64'd1);
    chk("SLT result", 64'(ALUOut), 64'd1);
    op = 5'b00000;
    dataA = 8'h03;
    dataB = 8'h04;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold result", 64'(ALUOut), 64'd1);
      chk("hold flags", 64'({Overflow, Carry, Negative, Zero}), 64'd0);
      chk("hold valid", 64'(out_valid), 64'd1);
      chk("hold in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("after take valid", 64'(out_valid), 64'd0);
    chk("after take in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pending ADD valid", 64'(out_valid), 64'd1);
    chk("pending ADD result", 64'(ALUOut), 64'h07);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
